// File: rtl/pool_window_sched.sv
// 2x2 max-pool window scheduler: walks a two-port input-map read pattern per group,
// aligns datapath control and output writes, and handshakes with neighbouring layers.
module pool_window_sched #(
   parameter int unsigned IFM_SIZE        = 10,
   parameter int unsigned IFM_DEPTH       = 16,
   parameter int unsigned NUMBER_OF_UNITS = 3,
   localparam int unsigned OUT_SIZE = IFM_SIZE / 2,
   localparam int unsigned GROUPS   = (IFM_DEPTH + NUMBER_OF_UNITS - 1) / NUMBER_OF_UNITS,
   localparam int unsigned AW       = $clog2(IFM_SIZE * IFM_SIZE),
   localparam int unsigned OAW      = $clog2(OUT_SIZE * OUT_SIZE),
   localparam int unsigned SW       = $clog2(IFM_DEPTH / NUMBER_OF_UNITS + 1)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start_from_previous,
   input  logic           conv_ready,
   input  logic           end_from_next,
   output logic           end_to_previous,
   output logic           rd_en_a,
   output logic           rd_en_b,
   output logic [AW-1:0]  rd_addr_a,
   output logic [AW-1:0]  rd_addr_b,
   output logic           win_first,
   output logic           win_last,
   output logic           wr_en_next,
   output logic [OAW-1:0] wr_addr_next,
   output logic [SW-1:0]  ifm_sel_next,
   output logic           start_to_next,
   output logic           busy
);

   localparam int unsigned CW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  r_q, r_d, c_q, c_d;
   logic           ph_q, ph_d;
   logic [SW-1:0]  g_q, g_d;
   logic           adv_q, adv_d;
   logic           pend_q, pend_d;
   logic           nb_q, nb_d;
   logic [1:0]     dcnt_q, dcnt_d;
   logic           issue_c;
   logic [AW-1:0]  addr_a_c, addr_b_c;
   logic [OAW-1:0] oaddr_c;

   logic           rd_en_q, rd_first_q, wf_q, wl_q, wr_q, stn_q, busy_q;
   logic [AW-1:0]  rda_q, rdb_q;
   logic [OAW-1:0] oa_q, oa2_q, wra_q;

   // window corner addresses for the current (r, c, phase)
   always_comb begin
      addr_a_c = AW'(32'(r_q) * (2 * IFM_SIZE) + 32'(c_q) * 2 + 32'(ph_q));
      addr_b_c = AW'(32'(r_q) * (2 * IFM_SIZE) + IFM_SIZE + 32'(c_q) * 2 + 32'(ph_q));
      oaddr_c  = OAW'(32'(r_q) * OUT_SIZE + 32'(c_q));
   end

   // next-state and issue decision
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      c_d     = c_q;
      ph_d    = ph_q;
      g_d     = g_q;
      adv_d   = 1'b0;
      pend_d  = pend_q;
      nb_d    = nb_q;
      dcnt_d  = dcnt_q;
      issue_c = 1'b0;

      // set wins over a simultaneous clear
      if (state_q == S_DONE) begin
         nb_d = 1'b1;
      end else if (end_from_next) begin
         nb_d = 1'b0;
      end

      if (start_from_previous && (state_q != S_IDLE)) begin
         pend_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start_from_previous || pend_q) begin
               state_d = S_WAIT;
               pend_d  = 1'b0;
            end
         end
         S_WAIT: begin
            if (conv_ready && !nb_q) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (adv_q) begin
               g_d = g_q + SW'(1);
            end else if (ph_q) begin
               issue_c = 1'b1;
               ph_d    = 1'b0;
               if (c_q == CW'(OUT_SIZE - 1)) begin
                  c_d = '0;
                  if (r_q == CW'(OUT_SIZE - 1)) begin
                     r_d = '0;
                     if (g_q == SW'(GROUPS - 1)) begin
                        state_d = S_DRAIN;
                        dcnt_d  = '0;
                     end else begin
                        adv_d = 1'b1;
                     end
                  end else begin
                     r_d = r_q + CW'(1);
                  end
               end else begin
                  c_d = c_q + CW'(1);
               end
            end else if ((r_q != '0) || (c_q != '0) || conv_ready) begin
               issue_c = 1'b1;
               ph_d    = 1'b1;
            end
         end
         S_DRAIN: begin
            dcnt_d = dcnt_q + 2'd1;
            if (dcnt_q == 2'd2) begin
               state_d = S_DONE;
               g_d     = '0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // state, counters and the registered read/datapath/write pipeline
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         r_q        <= '0;
         c_q        <= '0;
         ph_q       <= 1'b0;
         g_q        <= '0;
         adv_q      <= 1'b0;
         pend_q     <= 1'b0;
         nb_q       <= 1'b0;
         dcnt_q     <= '0;
         rd_en_q    <= 1'b0;
         rda_q      <= '0;
         rdb_q      <= '0;
         rd_first_q <= 1'b0;
         wf_q       <= 1'b0;
         wl_q       <= 1'b0;
         oa_q       <= '0;
         oa2_q      <= '0;
         wr_q       <= 1'b0;
         wra_q      <= '0;
         stn_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         r_q        <= r_d;
         c_q        <= c_d;
         ph_q       <= ph_d;
         g_q        <= g_d;
         adv_q      <= adv_d;
         pend_q     <= pend_d;
         nb_q       <= nb_d;
         dcnt_q     <= dcnt_d;
         rd_en_q    <= issue_c;
         rda_q      <= issue_c ? addr_a_c : '0;
         rdb_q      <= issue_c ? addr_b_c : '0;
         rd_first_q <= issue_c & ~ph_q;
         wf_q       <= rd_en_q & rd_first_q;
         wl_q       <= rd_en_q & ~rd_first_q;
         if (issue_c && ph_q) begin
            oa_q <= oaddr_c;
         end
         oa2_q      <= oa_q;
         wr_q       <= wl_q;
         wra_q      <= wl_q ? oa2_q : '0;
         stn_q      <= (state_d == S_DONE);
         busy_q     <= (state_d != S_IDLE);
      end
   end

   assign rd_en_a         = rd_en_q;
   assign rd_en_b         = rd_en_q;
   assign rd_addr_a       = rda_q;
   assign rd_addr_b       = rdb_q;
   assign win_first       = wf_q;
   assign win_last        = wl_q;
   assign wr_en_next      = wr_q;
   assign wr_addr_next    = wra_q;
   assign ifm_sel_next    = g_q;
   assign start_to_next   = stn_q;
   assign end_to_previous = stn_q;
   assign busy            = busy_q;

endmodule

// File: tb/tb_pool_window_sched.sv
// Scoreboard bench for pool_window_sched at default parameters (10x10 maps, 6 groups).
module tb_pool_window_sched;

   localparam int unsigned IFM = 10;
   localparam int unsigned OS  = 5;
   localparam int unsigned NG  = 6;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start_from_previous = 1'b0;
   logic       conv_ready = 1'b1;
   logic       end_from_next = 1'b0;
   logic       end_to_previous, rd_en_a, rd_en_b, win_first, win_last;
   logic       wr_en_next, start_to_next, busy;
   logic [6:0] rd_addr_a, rd_addr_b;
   logic [4:0] wr_addr_next;
   logic [2:0] ifm_sel_next;

   pool_window_sched dut (
      .clk(clk), .reset(reset), .start_from_previous(start_from_previous),
      .conv_ready(conv_ready), .end_from_next(end_from_next),
      .end_to_previous(end_to_previous), .rd_en_a(rd_en_a), .rd_en_b(rd_en_b),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .win_first(win_first),
      .win_last(win_last), .wr_en_next(wr_en_next), .wr_addr_next(wr_addr_next),
      .ifm_sel_next(ifm_sel_next), .start_to_next(start_to_next), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned a;
      int unsigned b;
      int unsigned g;
      bit          ph;
   } rd_t;

   rd_t         rdq[$];
   int unsigned wrq[$];
   int          total = 0;
   int          bad = 0;
   int unsigned rd_cnt = 0, wr_cnt = 0, stn_cnt = 0, last_wr = 0;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // expected read sequence and write addresses for one full frame
   task automatic push_frame();
      rd_t e;
      for (int g = 0; g < NG; g++)
         for (int r = 0; r < OS; r++)
            for (int c = 0; c < OS; c++) begin
               for (int p = 0; p < 2; p++) begin
                  e.a  = 2 * r * IFM + 2 * c + p;
                  e.b  = (2 * r + 1) * IFM + 2 * c + p;
                  e.g  = g;
                  e.ph = (p == 1);
                  rdq.push_back(e);
               end
               wrq.push_back(r * OS + c);
            end
   endtask

   // monitor: pops the scoreboard whenever the DUT reads or writes
   initial begin : monitor
      bit  wf_s, wl_s, wr_s, nwf, nwl;
      rd_t e;
      wf_s = 0; wl_s = 0; wr_s = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            wf_s = 0; wl_s = 0; wr_s = 0;
         end else begin
            nwf = 0; nwl = 0;
            check("win_first_align", win_first, wf_s);
            check("win_last_align", win_last, wl_s);
            check("wr_en_align", wr_en_next, wr_s);
            check("rd_en_b_eq_a", rd_en_b, rd_en_a);
            check("end_to_prev_eq", end_to_previous, start_to_next);
            if (rd_en_a) begin
               rd_cnt++;
               if (rdq.size() == 0) begin
                  check("unexpected_read", 1, 0);
               end else begin
                  e = rdq.pop_front();
                  check("rd_addr_a", rd_addr_a, e.a);
                  check("rd_addr_b", rd_addr_b, e.b);
                  check("ifm_sel_on_read", ifm_sel_next, e.g);
                  nwf = !e.ph;
                  nwl = e.ph;
               end
            end else begin
               check("rd_addr_idle_zero", {rd_addr_a, rd_addr_b}, 0);
            end
            if (wr_en_next) begin
               wr_cnt++;
               last_wr = wr_addr_next;
               if (wrq.size() == 0) check("unexpected_write", 1, 0);
               else check("wr_addr", wr_addr_next, wrq.pop_front());
            end else begin
               check("wr_addr_idle_zero", wr_addr_next, 0);
            end
            if (start_to_next) stn_cnt++;
            wr_s = wl_s;
            wl_s = nwl;
            wf_s = nwf;
         end
      end
   end

   task automatic pulse_start();
      @(negedge clk) start_from_previous = 1'b1;
      @(negedge clk) start_from_previous = 1'b0;
   endtask

   task automatic pulse_end();
      @(negedge clk) end_from_next = 1'b1;
      @(negedge clk) end_from_next = 1'b0;
   endtask

   task automatic wait_done(input int unsigned target);
      int n = 0;
      while (stn_cnt < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("frame_done_in_time", (stn_cnt >= target), 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_all_zero(input string name);
      check(name, {end_to_previous, rd_en_a, rd_en_b, rd_addr_a, rd_addr_b, win_first,
                   win_last, wr_en_next, wr_addr_next, ifm_sel_next, start_to_next, busy}, 0);
   endtask

   initial begin : stimulus
      int unsigned w0, r0, s0;
      int n;
      #23;
      check_all_zero("reset_outputs");
      @(negedge clk) reset = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_without_start", busy, 0);

      // frame 1: full frame with a 5-cycle conv_ready stall at the start of group 2
      w0 = wr_cnt; s0 = stn_cnt;
      push_frame();
      pulse_start();
      n = 0;
      while (ifm_sel_next != 3'd2 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("sel2_reached", (n < 2000), 1);
      conv_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_no_read", rd_en_a, 0);
         check("stall_sel_hold", ifm_sel_next, 2);
      end
      conv_ready = 1'b1;
      wait_done(s0 + 1);
      check("frame1_writes", wr_cnt - w0, 150);
      check("frame1_done_pulses", stn_cnt - s0, 1);
      check("frame1_last_addr", last_wr, 24);
      check("frame1_sel_back", ifm_sel_next, 0);
      check("frame1_idle", busy, 0);

      // frame 2: start while next layer still busy holds in WAIT
      push_frame();
      r0 = rd_cnt; s0 = stn_cnt;
      pulse_start();
      repeat (20) @(negedge clk);
      check("wait_busy", busy, 1);
      check("wait_no_reads", rd_cnt - r0, 0);
      @(negedge clk) end_from_next = 1'b1;
      @(negedge clk) end_from_next = 1'b0;
      n = 0;
      while (!rd_en_a && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("wait_release_latency", n, 2);

      // two starts during RUN queue exactly one more frame; stray end is ignored
      repeat (10) @(negedge clk);
      push_frame();
      pulse_start();
      repeat (5) @(negedge clk);
      pulse_start();
      pulse_end();
      wait_done(s0 + 1);
      r0 = rd_cnt;
      repeat (10) @(negedge clk);
      check("pending_waits_busy", busy, 1);
      check("pending_waits_no_reads", rd_cnt - r0, 0);
      pulse_end();
      wait_done(s0 + 2);
      r0 = rd_cnt;
      repeat (30) @(negedge clk);
      check("no_extra_frame_reads", rd_cnt - r0, 0);
      check("no_extra_frame_idle", busy, 0);
      check("frames_2_3_pulses", stn_cnt - s0, 2);

      // frame 4: reset during group 3, window 7
      pulse_end();
      push_frame();
      s0 = stn_cnt;
      pulse_start();
      n = 0;
      while (!(rd_en_a && ifm_sel_next == 3'd3 && rd_addr_a == 7'd24 && rd_addr_b == 7'd34)
             && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("reset_point_reached", (n < 2000), 1);
      #2 reset = 1'b0;
      #1 check_all_zero("async_reset_outputs");
      rdq.delete();
      wrq.delete();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      r0 = rd_cnt; w0 = wr_cnt;
      repeat (10) @(negedge clk);
      check("post_reset_idle", busy, 0);
      check("post_reset_no_reads", rd_cnt - r0, 0);
      check("post_reset_no_writes", wr_cnt - w0, 0);
      check("post_reset_no_done", stn_cnt - s0, 0);

      // frame 5: fresh start after reset runs without end_from_next
      push_frame();
      w0 = wr_cnt;
      pulse_start();
      wait_done(s0 + 1);
      check("frame5_writes", wr_cnt - w0, 150);
      check("frame5_last_addr", last_wr, 24);
      check("scoreboard_rd_empty", rdq.size(), 0);
      check("scoreboard_wr_empty", wrq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/pool_window_sched.md
POOL_WINDOW_SCHED -- requirements
Module: pool_window_sched

Interface
REQ-001 SHALL have parameter IFM_SIZE, default 10, input map side in pixels (even).
REQ-002 SHALL have parameter IFM_DEPTH, default 16, number of input maps.
REQ-003 SHALL have parameter NUMBER_OF_UNITS, default 3, maps pooled in parallel per group.
REQ-004 SHALL have derived parameters:
- OUT_SIZE = IFM_SIZE/2
- GROUPS = ceil(IFM_DEPTH/NUMBER_OF_UNITS)
- AW = $clog2(IFM_SIZE*IFM_SIZE)
- OAW = $clog2(OUT_SIZE*OUT_SIZE)
- SW = $clog2(IFM_DEPTH/NUMBER_OF_UNITS+1)
REQ-005 SHALL have ports; one clock; reset asynchronous, active-low:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous active-low reset
- start_from_previous  in  1  pulse, input maps ready
- conv_ready  in  1  next layer buffer may be written
- end_from_next  in  1  pulse, next layer finished consuming last output
- end_to_previous  out  1  pulse, input maps released
- rd_en_a / rd_en_b  out  1  read enables, ports A/B
- rd_addr_a / rd_addr_b  out  AW  read addresses
- win_first  out  1  datapath loads column-0 pair
- win_last  out  1  datapath compares column-1 pair
- wr_en_next  out  1  write pooled result
- wr_addr_next  out  OAW  output address
- ifm_sel_next  out  SW  current group index
- start_to_next  out  1  pulse, output maps complete
- busy  out  1  high outside IDLE

Function
REQ-006 SHALL implement states IDLE, WAIT, RUN, DRAIN, DONE.
REQ-007 IDLE->WAIT when start_from_previous=1 or pending flag set; pending flag then cleared.
REQ-008 WAIT->RUN on first cycle where conv_ready=1 and next_busy=0; otherwise hold, no reads.
REQ-009 RUN issues window (r,c), r,c in 0..OUT_SIZE-1, row-major, over two cycles:
- cycle t: A=(2r)*IFM_SIZE+2c, B=(2r+1)*IFM_SIZE+2c
- cycle t+1: A and B addresses +1
- rd_en_a = rd_en_b = 1 both cycles
REQ-010 Memory read latency is 1 cycle: win_first=1 at t+1, win_last=1 at t+2.
REQ-011 wr_en_next=1 at t+3 with wr_addr_next=r*OUT_SIZE+c; sustained rate one window per 2 cycles, no bubbles inside a group.
REQ-012 After the last window of a group, if more groups remain: ifm_sel_next +1 on the cycle following the last issue; next group's first issue requires conv_ready=1 (stall in RUN with rd_en=0 otherwise).
REQ-013 After the last window of group GROUPS-1: RUN->DRAIN; DRAIN lasts exactly 3 cycles so the final wr_en_next occurs; then ->DONE.
REQ-014 DONE lasts 1 cycle:
- start_to_next=1 and end_to_previous=1
- sets next_busy=1, ifm_sel_next returns to 0
- ->IDLE
REQ-015 next_busy cleared by end_from_next; end_from_next and set in the same cycle: set wins.
REQ-016 start_from_previous outside IDLE sets a one-deep pending flag; further pulses while pending are dropped.
REQ-017 rd_addr_*, wr_addr_next SHALL be 0 whenever their enable is 0.
REQ-018 Address arithmetic SHALL be unsigned, never exceeding IFM_SIZE*IFM_SIZE-1 / OUT_SIZE*OUT_SIZE-1; no wrap.
REQ-019 end_from_next while next_busy=0 SHALL be ignored.

Reset
REQ-020 reset=0 SHALL asynchronously force IDLE, all outputs 0, counters 0, pending=0, next_busy=0, including mid-RUN; no partial write after release.
REQ-021 First transition after reset release SHALL need a fresh start_from_previous.

Verification
REQ-022 Defaults, conv_ready=1, start pulse -> first issue A=0,B=10 then A=1,B=11; 2nd window A=2,B=12; first wr_en_next at issue+3, addr 0.
REQ-023 Full frame -> 25 writes per group, 6 groups, ifm_sel_next 0..5, 150 writes total, single start_to_next/end_to_previous pulse, last write addr 24.
REQ-024 conv_ready=0 at start of group 2 for 5 cycles -> no reads for 5 cycles, ifm_sel_next holds 2, resume with A=0,B=10.
REQ-025 Second start before end_from_next -> scheduler waits in WAIT; end_from_next -> RUN next cycle.
REQ-026 reset=0 during group 3 window 7 -> all outputs 0 same cycle; after release stays IDLE until new start.
REQ-027 start_from_previous twice during RUN -> exactly one additional frame after DONE.
